// File: rtl/turn_sequencer_pkg.sv
// Shared types, encodings and board helpers for the tic-tac-toe turn sequencer.
package turn_sequencer_pkg;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned CELL_W  = 2;
    localparam int unsigned BOARD_W = N_CELLS * CELL_W;
    localparam int unsigned POS_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned N_LINES = 8;

    typedef logic [CELL_W-1:0]  cell_t;
    typedef logic [BOARD_W-1:0] board_t;
    typedef logic [POS_W-1:0]   pos_t;

    localparam cell_t CELL_EMPTY  = 2'b00;
    localparam cell_t CELL_X      = 2'b01;
    localparam cell_t CELL_O      = 2'b10;
    localparam cell_t WINNER_DRAW = 2'b11;

    typedef enum logic [1:0] {
        S_WAIT_X = 2'd0,
        S_WAIT_O = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        pos_t a;
        pos_t b;
        pos_t c;
    } line_t;

    // Rows, columns, then the two diagonals (row-major cell indices).
    localparam line_t LINES [N_LINES] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    // Out-of-range indices read as empty; callers range-check separately.
    function automatic cell_t cell_at(board_t b, pos_t idx);
        cell_t c;
        c = CELL_EMPTY;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (idx == POS_W'(i)) c = b[i*CELL_W +: CELL_W];
        end
        return c;
    endfunction

    function automatic board_t set_cell(board_t b, pos_t idx, cell_t v);
        board_t r;
        r = b;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (idx == POS_W'(i)) r[i*CELL_W +: CELL_W] = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/turn_sequencer_line_checker.sv
// Combinational three-in-a-row detector for one player over the whole board.
module turn_sequencer_line_checker
    import turn_sequencer_pkg::*;
(
    input  board_t board,
    input  cell_t  player,
    output logic   win
);

    always_comb begin
        win = 1'b0;
        for (int l = 0; l < int'(N_LINES); l++) begin
            if (cell_at(board, LINES[l].a) == player &&
                cell_at(board, LINES[l].b) == player &&
                cell_at(board, LINES[l].c) == player) begin
                win = 1'b1;
            end
        end
        // Only real marks can win; empty lines must not match.
        if (player == CELL_EMPTY || player == WINNER_DRAW) win = 1'b0;
    end

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe game controller: owns the board, arbitrates X/O turns, detects win/draw.
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter cell_t FIRST_PLAYER = 2'b01
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             new_game,
    input  logic             req_x,
    input  logic [POS_W-1:0] pos_x,
    input  logic             req_o,
    input  logic [POS_W-1:0] pos_o,
    output logic             ack_x,
    output logic             ack_o,
    output logic             rej_x,
    output logic             rej_o,
    output board_t           board,
    output cell_t            turn,
    output logic             game_over,
    output cell_t            winner
);

    localparam state_t FIRST_STATE = (FIRST_PLAYER == CELL_O) ? S_WAIT_O : S_WAIT_X;

    state_t           state;
    logic [CNT_W-1:0] move_cnt;
    cell_t            player;
    logic             win;
    logic             valid_x;
    logic             valid_o;

    assign valid_x = (pos_x < POS_W'(N_CELLS)) && (cell_at(board, pos_x) == CELL_EMPTY);
    assign valid_o = (pos_o < POS_W'(N_CELLS)) && (cell_at(board, pos_o) == CELL_EMPTY);

    turn_sequencer_line_checker u_line_checker (
        .board  (board),
        .player (player),
        .win    (win)
    );

    // Game FSM; a request seen while its own rej is high is skipped so a held bad move rejects every other cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FIRST_STATE;
            board     <= '0;
            move_cnt  <= '0;
            player    <= FIRST_PLAYER;
            turn      <= FIRST_PLAYER;
            ack_x     <= 1'b0;
            ack_o     <= 1'b0;
            rej_x     <= 1'b0;
            rej_o     <= 1'b0;
            game_over <= 1'b0;
            winner    <= CELL_EMPTY;
        end else begin
            ack_x <= 1'b0;
            ack_o <= 1'b0;
            rej_x <= 1'b0;
            rej_o <= 1'b0;
            if (new_game) begin
                state     <= FIRST_STATE;
                board     <= '0;
                move_cnt  <= '0;
                player    <= FIRST_PLAYER;
                turn      <= FIRST_PLAYER;
                game_over <= 1'b0;
                winner    <= CELL_EMPTY;
            end else begin
                case (state)
                    S_WAIT_X: begin
                        if (req_x && !rej_x) begin
                            if (valid_x) begin
                                board    <= set_cell(board, pos_x, CELL_X);
                                move_cnt <= move_cnt + CNT_W'(1);
                                player   <= CELL_X;
                                turn     <= CELL_EMPTY;
                                ack_x    <= 1'b1;
                                state    <= S_CHECK;
                            end else begin
                                rej_x <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_O: begin
                        if (req_o && !rej_o) begin
                            if (valid_o) begin
                                board    <= set_cell(board, pos_o, CELL_O);
                                move_cnt <= move_cnt + CNT_W'(1);
                                player   <= CELL_O;
                                turn     <= CELL_EMPTY;
                                ack_o    <= 1'b1;
                                state    <= S_CHECK;
                            end else begin
                                rej_o <= 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        // A win takes priority over a full board.
                        if (win) begin
                            winner    <= player;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if (move_cnt == CNT_W'(N_CELLS)) begin
                            winner    <= WINNER_DRAW;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if (player == CELL_X) begin
                            turn  <= CELL_O;
                            state <= S_WAIT_O;
                        end else begin
                            turn  <= CELL_X;
                            state <= S_WAIT_X;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a pulse scoreboard and an independent board model.
module tb_turn_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        new_game;
    logic        req_x;
    logic [3:0]  pos_x;
    logic        req_o;
    logic [3:0]  pos_o;
    logic        ack_x;
    logic        ack_o;
    logic        rej_x;
    logic        rej_o;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        game_over;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  pulses;   // {ack_x, rej_x, ack_o, rej_o}
        logic [17:0] board;
    } exp_t;

    exp_t        sb[$];
    logic [17:0] m_board;
    int          m_cnt;

    turn_sequencer #(.FIRST_PLAYER(2'b01)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .new_game  (new_game),
        .req_x     (req_x),
        .pos_x     (pos_x),
        .req_o     (req_o),
        .pos_o     (pos_o),
        .ack_x     (ack_x),
        .ack_o     (ack_o),
        .rej_x     (rej_x),
        .rej_o     (rej_o),
        .board     (board),
        .turn      (turn),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] mcell(logic [17:0] b, int i);
        logic [17:0] t;
        t = b >> (2 * i);
        return t[1:0];
    endfunction

    function automatic bit mwin(logic [17:0] b, logic [1:0] p);
        bit w;
        w = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (mcell(b, 3*r) == p && mcell(b, 3*r+1) == p && mcell(b, 3*r+2) == p) w = 1'b1;
            if (mcell(b, r) == p && mcell(b, r+3) == p && mcell(b, r+6) == p) w = 1'b1;
        end
        if (mcell(b, 0) == p && mcell(b, 4) == p && mcell(b, 8) == p) w = 1'b1;
        if (mcell(b, 2) == p && mcell(b, 4) == p && mcell(b, 6) == p) w = 1'b1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every ack/rej pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && (ack_x | rej_x | ack_o | rej_o)) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_pulse observed=%b expected=none", {ack_x, rej_x, ack_o, rej_o});
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                assert ({ack_x, rej_x, ack_o, rej_o} === e.pulses) else begin
                    n_errors++;
                    $error("FAIL %s_pulse observed=%b expected=%b", e.tag, {ack_x, rej_x, ack_o, rej_o}, e.pulses);
                end
                n_checks++;
                assert (board === e.board) else begin
                    n_errors++;
                    $error("FAIL %s_board observed=%h expected=%h", e.tag, board, e.board);
                end
            end
        end
    end

    // One request from X (px=1) or O; waits for the response and checks the following turn state.
    task automatic move(input bit px, input logic [3:0] pos);
        exp_t       e;
        logic [1:0] p;
        bit         ok;
        bit         seen;
        p  = px ? 2'b01 : 2'b10;
        ok = (pos < 4'd9) && (mcell(m_board, int'(pos)) == 2'b00);
        if (ok) begin
            m_board = m_board | (18'(p) << (2 * int'(pos)));
            m_cnt++;
        end
        e.tag    = px ? "move_x" : "move_o";
        e.pulses = px ? (ok ? 4'b1000 : 4'b0100) : (ok ? 4'b0010 : 4'b0001);
        e.board  = m_board;
        sb.push_back(e);
        if (px) begin req_x = 1'b1; pos_x = pos; end
        else    begin req_o = 1'b1; pos_o = pos; end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clock);
            seen = px ? (ack_x | rej_x) : (ack_o | rej_o);
        end
        chk("move_response", 32'(seen), 32'd1);
        if (px) req_x = 1'b0; else req_o = 1'b0;
        if (ok && seen) begin
            chk("turn_during_check", 32'(turn), 32'd0);
            @(negedge clock);
            if (mwin(m_board, p)) begin
                chk("turn_after", 32'(turn), 32'd0);
                chk("game_over", 32'(game_over), 32'd1);
                chk("winner", 32'(winner), 32'(p));
            end else if (m_cnt == 9) begin
                chk("turn_after", 32'(turn), 32'd0);
                chk("game_over", 32'(game_over), 32'd1);
                chk("winner", 32'(winner), 32'd3);
            end else begin
                chk("turn_after", 32'(turn), px ? 32'd2 : 32'd1);
                chk("game_over", 32'(game_over), 32'd0);
            end
        end else if (!ok) begin
            chk("turn_after_rej", 32'(turn), 32'(p));
        end
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        m_board = '0;
        m_cnt   = 0;
        chk("ng_board", 32'(board), 32'd0);
        chk("ng_turn", 32'(turn), 32'd1);
        chk("ng_game_over", 32'(game_over), 32'd0);
        chk("ng_winner", 32'(winner), 32'd0);
    endtask

    initial begin
        int nz;
        reset_n  = 1'b0;
        new_game = 1'b0;
        req_x    = 1'b0;
        pos_x    = '0;
        req_o    = 1'b0;
        pos_o    = '0;
        m_board  = '0;
        m_cnt    = 0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_turn", 32'(turn), 32'd1);
        chk("rst_pulses", 32'({ack_x, rej_x, ack_o, rej_o}), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        reset_n = 1'b1;

        // O holds a request through X's whole turn; it must not be answered early.
        req_o = 1'b1;
        pos_o = 4'd4;
        @(negedge clock);
        move(1'b1, 4'd4);
        move(1'b0, 4'd4);
        @(negedge clock);

        // Held out-of-range index rejects on alternate cycles.
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.tag = "rej_repeat"; e.pulses = 4'b0001; e.board = m_board;
            sb.push_back(e);
        end
        req_o = 1'b1;
        pos_o = 4'd9;
        repeat (4) @(negedge clock);
        req_o = 1'b0;
        chk("rej_repeat_drained", 32'(sb.size()), 32'd0);
        chk("rej_turn", 32'(turn), 32'd2);
        @(negedge clock);

        // X wins on row 0.
        start_new_game();
        move(1'b1, 4'd0);
        move(1'b0, 4'd3);
        move(1'b1, 4'd1);
        move(1'b0, 4'd4);
        move(1'b1, 4'd2);
        chk("win_x_winner", 32'(winner), 32'd1);

        // DONE ignores everyone and freezes the board.
        req_x = 1'b1; pos_x = 4'd5;
        req_o = 1'b1; pos_o = 4'd6;
        repeat (4) @(negedge clock);
        req_x = 1'b0;
        req_o = 1'b0;
        chk("done_board", 32'(board), 32'(m_board));
        chk("done_game_over", 32'(game_over), 32'd1);

        // Full board with no line is a draw.
        start_new_game();
        move(1'b1, 4'd0); move(1'b0, 4'd1); move(1'b1, 4'd2);
        move(1'b0, 4'd4); move(1'b1, 4'd3); move(1'b0, 4'd6);
        move(1'b1, 4'd7); move(1'b0, 4'd8); move(1'b1, 4'd5);
        chk("draw_winner", 32'(winner), 32'd3);
        nz = 0;
        for (int i = 0; i < 9; i++) if (mcell(board, i) != 2'b00) nz++;
        chk("draw_cells_filled", 32'(nz), 32'd9);

        // Ninth move completes a line: winner, not draw.
        start_new_game();
        move(1'b1, 4'd1); move(1'b0, 4'd0); move(1'b1, 4'd2);
        move(1'b0, 4'd4); move(1'b1, 4'd3); move(1'b0, 4'd6);
        move(1'b1, 4'd5); move(1'b0, 4'd7); move(1'b1, 4'd8);
        chk("ninth_win_winner", 32'(winner), 32'd1);

        // new_game beats a simultaneous valid request.
        start_new_game();
        move(1'b1, 4'd0);
        move(1'b0, 4'd4);
        new_game = 1'b1;
        req_x    = 1'b1;
        pos_x    = 4'd8;
        @(negedge clock);
        new_game = 1'b0;
        req_x    = 1'b0;
        m_board  = '0;
        m_cnt    = 0;
        chk("ng_race_board", 32'(board), 32'd0);
        chk("ng_race_turn", 32'(turn), 32'd1);
        chk("ng_race_ack", 32'(ack_x), 32'd0);

        // Async reset in the CHECK cycle clears outputs without a clock edge.
        begin
            exp_t e;
            e.tag = "pre_reset"; e.pulses = 4'b1000; e.board = 18'h00100;
            sb.push_back(e);
        end
        req_x = 1'b1;
        pos_x = 4'd4;
        @(negedge clock);
        req_x = 1'b0;
        chk("pre_reset_ack", 32'(ack_x), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_board", 32'(board), 32'd0);
        chk("async_turn", 32'(turn), 32'd1);
        chk("async_ack", 32'(ack_x), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        m_board = '0;
        m_cnt   = 0;
        move(1'b1, 4'd8);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
